// File: rtl/ts_sync_cc_monitor.sv
// ts_sync_cc_monitor: per-channel MPEG-2 TS front-end monitor.
// Hunts for the 0x47 packet grid, parses each packet header while locked and
// checks continuity counters for up to NUM_PIDS learned PIDs.
// Ports:
//   clk        system clock
//   rstn       synchronous active-low reset
//   ts_data    TS byte, sampled when ts_valid is high
//   ts_valid   byte strobe (gaps allowed)
//   clr_count  clears err_count (an increment in the same cycle leaves 1)
//   valid      high while locked
//   sync       one-cycle pulse per accepted packet sync byte
//   err_count  saturating error count
module ts_sync_cc_monitor #(
    parameter int unsigned PKT_LEN  = 188,
    parameter int unsigned LOCK_N   = 3,
    parameter int unsigned LOSS_N   = 3,
    parameter int unsigned NUM_PIDS = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [7:0]       ts_data,
    input  logic             ts_valid,
    input  logic             clr_count,
    output logic             valid,
    output logic             sync,
    output logic [CNT_W-1:0] err_count
);
    localparam int unsigned POS_W = $clog2(PKT_LEN);
    localparam int unsigned HIT_W = $clog2(LOCK_N + 1);
    localparam int unsigned MIS_W = $clog2(LOSS_N + 1);
    localparam int unsigned IDX_W = (NUM_PIDS > 1) ? $clog2(NUM_PIDS) : 1;

    localparam logic [7:0]       SYNC_BYTE = 8'h47;
    localparam logic [12:0]      NULL_PID  = 13'h1FFF;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [POS_W-1:0] pos_q, pos_d, pos_inc;
    logic [HIT_W-1:0] hits_q, hits_d, hits_inc;
    logic [MIS_W-1:0] miss_q, miss_d, miss_inc;
    logic             parse_q, parse_d;
    logic             tei_q, tei_d;
    logic [12:0]      pid_q, pid_d;
    logic             valid_q, valid_d;
    logic             sync_q, sync_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             is_sync;
    logic             loss_evt;

    // PID/CC tracking table
    logic [NUM_PIDS-1:0] tbl_vld_q;
    logic [12:0]         tbl_pid_q [NUM_PIDS];
    logic [3:0]          tbl_cc_q  [NUM_PIDS];

    logic             chk_en;
    logic             hit, free;
    logic [IDX_W-1:0] hit_idx, free_idx;
    logic [3:0]       exp_cc;
    logic             cc_evt, upd_hit, upd_alloc;

    // Sync hunting, lock/flywheel and header capture
    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        hits_d   = hits_q;
        miss_d   = miss_q;
        parse_d  = parse_q;
        tei_d    = tei_q;
        pid_d    = pid_q;
        sync_d   = 1'b0;
        loss_evt = 1'b0;
        is_sync  = (ts_data == SYNC_BYTE);
        pos_inc  = (pos_q == POS_W'(PKT_LEN - 1)) ? '0 : pos_q + POS_W'(1);
        hits_inc = hits_q + HIT_W'(1);
        miss_inc = miss_q + MIS_W'(1);

        if (ts_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (is_sync) begin
                        state_d = VERIFY;
                        pos_d   = POS_W'(1);
                        hits_d  = HIT_W'(1);
                    end
                end
                VERIFY: begin
                    pos_d = pos_inc;
                    if (pos_q == '0) begin
                        if (is_sync) begin
                            hits_d = hits_inc;
                            if (hits_inc == HIT_W'(LOCK_N)) begin
                                state_d = LOCKED;
                                miss_d  = '0;
                                parse_d = 1'b1;
                                sync_d  = 1'b1;
                            end
                        end else begin
                            state_d = HUNT;
                            hits_d  = '0;
                            pos_d   = '0;
                        end
                    end
                end
                LOCKED: begin
                    pos_d = pos_inc;
                    if (pos_q == '0) begin
                        if (is_sync) begin
                            miss_d  = '0;
                            parse_d = 1'b1;
                            sync_d  = 1'b1;
                        end else begin
                            parse_d = 1'b0;
                            miss_d  = miss_inc;
                            if (miss_inc == MIS_W'(LOSS_N)) begin
                                state_d  = HUNT;
                                pos_d    = '0;
                                hits_d   = '0;
                                miss_d   = '0;
                                loss_evt = 1'b1;
                            end
                        end
                    end else if (parse_q) begin
                        if (pos_q == POS_W'(1)) begin
                            tei_d       = ts_data[7];
                            pid_d[12:8] = ts_data[4:0];
                        end
                        if (pos_q == POS_W'(2)) begin
                            pid_d[7:0] = ts_data;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // CC check on the pos3 beat of a parsed packet
    assign chk_en = ts_valid && (state_q == LOCKED) && parse_q && (pos_q == POS_W'(3));

    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int i = 0; i < int'(NUM_PIDS); i++) begin
            if (!hit && tbl_vld_q[i] && (tbl_pid_q[i] == pid_q)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!free && !tbl_vld_q[i]) begin
                free     = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
        // AFC bit 0 set means payload present, so CC must advance
        exp_cc    = ts_data[4] ? tbl_cc_q[hit_idx] + 4'd1 : tbl_cc_q[hit_idx];
        cc_evt    = 1'b0;
        upd_hit   = 1'b0;
        upd_alloc = 1'b0;
        if (chk_en) begin
            if (tei_q) begin
                cc_evt = 1'b1;
            end else if (pid_q != NULL_PID) begin
                if (hit) begin
                    upd_hit = 1'b1;
                    cc_evt  = (ts_data[3:0] != exp_cc);
                end else if (free) begin
                    upd_alloc = 1'b1;
                end
            end
        end
    end

    // Saturating error counter with clear; events never coincide
    always_comb begin
        err_d = err_q;
        if (clr_count) begin
            err_d = (cc_evt || loss_evt) ? CNT_W'(1) : '0;
        end else if ((cc_evt || loss_evt) && (err_q != CNT_MAX)) begin
            err_d = err_q + CNT_W'(1);
        end
        valid_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= HUNT;
            pos_q   <= '0;
            hits_q  <= '0;
            miss_q  <= '0;
            parse_q <= 1'b0;
            tei_q   <= 1'b0;
            pid_q   <= '0;
            valid_q <= 1'b0;
            sync_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            hits_q  <= hits_d;
            miss_q  <= miss_d;
            parse_q <= parse_d;
            tei_q   <= tei_d;
            pid_q   <= pid_d;
            valid_q <= valid_d;
            sync_q  <= sync_d;
            err_q   <= err_d;
        end
    end

    // Table storage; only the valid bits need reset
    always_ff @(posedge clk) begin
        if (!rstn || loss_evt) begin
            tbl_vld_q <= '0;
        end else if (upd_alloc) begin
            tbl_vld_q[free_idx] <= 1'b1;
            tbl_pid_q[free_idx] <= pid_q;
            tbl_cc_q[free_idx]  <= ts_data[3:0];
        end else if (upd_hit) begin
            tbl_cc_q[hit_idx] <= ts_data[3:0];
        end
    end

    assign valid     = valid_q;
    assign sync      = sync_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_ts_sync_cc_monitor.sv
// Directed bench for ts_sync_cc_monitor: lock, CC checking, table limits,
// lock loss, counter clear and saturation.
module tb_ts_sync_cc_monitor;
    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] ts_data;
    logic       ts_valid;
    logic       clr_count;
    logic       valid;
    logic       sync;
    logic [7:0] err_count;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    int unsigned n_fail  = 0;

    logic [31:0] s_valid0, s_sync0, s_err0, s_sync1, s_err3;
    bit          clr_at3 = 1'b0;

    always #5 clk = ~clk;

    ts_sync_cc_monitor dut (
        .clk       (clk),
        .rstn      (rstn),
        .ts_data   (ts_data),
        .ts_valid  (ts_valid),
        .clr_count (clr_count),
        .valid     (valid),
        .sync      (sync),
        .err_count (err_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock with a byte on the bus; returns 1ns after the edge
    task automatic send_byte(input logic [7:0] b);
        ts_data  = b;
        ts_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ts_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Full 188-byte packet; snapshots outputs after pos0, the following cycle and pos3
    task automatic pkt(input int sb, input int tei, input int pid, input int afc,
                       input int cc, input int gap);
        logic [7:0] b;
        for (int p = 0; p < 188; p++) begin
            case (p)
                0:       b = 8'(sb);
                1:       b = {1'(tei), 2'b00, 5'(pid >> 8)};
                2:       b = 8'(pid);
                3:       b = {2'b00, 2'(afc), 4'(cc)};
                default: b = 8'hFF;
            endcase
            clr_count = clr_at3 && (p == 3);
            send_byte(b);
            clr_count = 1'b0;
            if (p == 0) begin
                s_valid0 = 32'(valid);
                s_sync0  = 32'(sync);
                s_err0   = 32'(err_count);
                if (gap != 0) begin
                    idle();
                    s_sync1 = 32'(sync);
                end
            end
            if (p == 1 && gap == 0) s_sync1 = 32'(sync);
            if (p == 3) s_err3 = 32'(err_count);
        end
        ts_valid = 1'b0;
    endtask

    initial begin
        rstn      = 1'b0;
        ts_valid  = 1'b0;
        ts_data   = 8'h00;
        clr_count = 1'b0;

        // 1. reset with random traffic
        for (int i = 0; i < 2; i++) begin
            ts_valid = 1'($urandom_range(0, 1));
            ts_data  = 8'($urandom);
            @(posedge clk);
            #1;
            check("rst_valid", 32'(valid), 0);
            check("rst_sync", 32'(sync), 0);
            check("rst_err", 32'(err_count), 0);
        end
        rstn = 1'b1;
        idle();

        // 2. clean lock on PID 0x100
        pkt(8'h47, 0, 13'h100, 1, 0, 0);
        check("p1_valid", s_valid0, 0);
        check("p1_sync", s_sync0, 0);
        pkt(8'h47, 0, 13'h100, 1, 1, 0);
        check("p2_valid", s_valid0, 0);
        pkt(8'h47, 0, 13'h100, 1, 2, 0);
        check("lock_valid", s_valid0, 1);
        check("lock_sync", s_sync0, 1);
        check("lock_sync_1cyc", s_sync1, 0);
        check("lock_err", s_err3, 0);
        pkt(8'h47, 0, 13'h100, 1, 3, 1);
        check("p4_sync", s_sync0, 1);
        check("p4_gap_sync0", s_sync1, 0);
        pkt(8'h47, 0, 13'h100, 1, 4, 0);
        check("p5_sync", s_sync0, 1);
        check("p5_err", s_err3, 0);

        // 3. CC errors
        pkt(8'h47, 0, 13'h100, 1, 7, 0);
        check("cc_jump", s_err3, 1);
        pkt(8'h47, 0, 13'h100, 2, 7, 0);
        check("afc10_same", s_err3, 1);
        pkt(8'h47, 0, 13'h100, 1, 7, 1);
        check("afc01_same", s_err3, 2);
        pkt(8'h47, 1, 13'h100, 1, 0, 0);
        check("tei", s_err3, 3);
        pkt(8'h47, 0, 13'h100, 1, 8, 0);
        check("tei_no_update", s_err3, 3);

        // reset mid-stream clears everything
        rstn = 1'b0;
        idle();
        check("rst2_valid", 32'(valid), 0);
        check("rst2_err", 32'(err_count), 0);
        rstn = 1'b1;

        // 4. table limits
        pkt(8'h47, 0, 13'h10, 1, 0, 0);
        pkt(8'h47, 0, 13'h10, 1, 0, 0);
        check("t4_verify_valid", s_valid0, 0);
        pkt(8'h47, 0, 13'h10, 1, 0, 0);
        check("t4_lock_valid", s_valid0, 1);
        pkt(8'h47, 0, 13'h11, 1, 0, 0);
        pkt(8'h47, 0, 13'h12, 1, 0, 0);
        pkt(8'h47, 0, 13'h13, 1, 0, 0);
        pkt(8'h47, 0, 13'h14, 1, 0, 0);
        check("t4_alloc_err", s_err3, 0);
        pkt(8'h47, 0, 13'h10, 1, 5, 0);
        check("pid10_err", s_err3, 1);
        pkt(8'h47, 0, 13'h11, 1, 9, 0);
        check("pid11_err", s_err3, 2);
        pkt(8'h47, 0, 13'h12, 1, 2, 0);
        check("pid12_err", s_err3, 3);
        pkt(8'h47, 0, 13'h13, 1, 15, 0);
        check("pid13_err", s_err3, 4);
        pkt(8'h47, 0, 13'h14, 1, 7, 0);
        pkt(8'h47, 0, 13'h14, 1, 1, 0);
        check("pid14_untracked", s_err3, 4);
        pkt(8'h47, 0, 13'h1FFF, 1, int'($urandom_range(0, 15)), 0);
        pkt(8'h47, 0, 13'h1FFF, 1, int'($urandom_range(0, 15)), 0);
        check("null_pid", s_err3, 4);
        pkt(8'h47, 0, 13'h10, 0, 5, 0);
        check("afc00_same", s_err3, 4);
        pkt(8'h47, 0, 13'h11, 3, 10, 0);
        check("afc11_incr", s_err3, 4);

        // 5. lock loss
        pkt(8'h00, 0, 13'h10, 1, 0, 0);
        check("miss1_valid", s_valid0, 1);
        check("miss1_sync", s_sync0, 0);
        pkt(8'h00, 0, 13'h10, 1, 0, 0);
        check("miss2_valid", s_valid0, 1);
        check("miss2_err", s_err0, 4);
        pkt(8'h00, 0, 13'h10, 1, 0, 0);
        check("loss_valid", s_valid0, 0);
        check("loss_err", s_err0, 5);
        pkt(8'h47, 0, 13'h10, 1, 12, 0);
        pkt(8'h47, 0, 13'h10, 1, 12, 0);
        pkt(8'h47, 0, 13'h10, 1, 12, 0);
        check("relock_valid", s_valid0, 1);
        check("table_cleared", s_err3, 5);
        pkt(8'h47, 0, 13'h100, 1, 3, 0);
        pkt(8'h47, 0, 13'h100, 1, 4, 0);
        check("pid100_realloc", s_err3, 5);
        pkt(8'h47, 0, 13'h10, 1, 13, 0);
        check("pid10_retracked", s_err3, 5);
        clr_at3 = 1'b1;
        pkt(8'h47, 0, 13'h100, 1, 9, 0);
        clr_at3 = 1'b0;
        check("clr_with_event", s_err3, 1);
        check("clr_keeps_valid", 32'(valid), 1);

        // 6. saturation
        for (int k = 1; k <= 258; k++) begin
            pkt(8'h47, 0, 13'h100, 1, 9, 0);
            if (k == 100) check("sat_k100", s_err3, 101);
            if (k == 254) check("sat_k254", s_err3, 255);
        end
        check("sat_hold", s_err3, 255);
        clr_count = 1'b1;
        idle();
        clr_count = 1'b0;
        check("clr_no_event", 32'(err_count), 0);
        check("clr_idle_valid", 32'(valid), 1);
        check("idle_sync", 32'(sync), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/ts_sync_cc_monitor.md
Name: ts_sync_cc_monitor

Overview:
Per-channel MPEG-2 TS front-end monitor, one instance per input stream, sitting directly upstream of the channel-selection controller.
- Locks onto the 188-byte packet grid by hunting for 0x47 sync bytes.
- Parses the 4-byte header of every packet while locked.
- Checks continuity counters (CC) per PID in a small learned table.
- Produces the `valid`, `sync` and 8-bit saturating `err_count` signals that the controller consumes.
- The controller clears `err_count` with its reset-counter strobe at the end of each evaluation window.

Parameters:
- PKT_LEN, 188, packet length in bytes.
- LOCK_N, 3, consecutive correctly spaced sync bytes required to lock.
- LOSS_N, 3, consecutive missing sync bytes that drop lock.
- NUM_PIDS, 4, number of PID/CC tracking entries.
- CNT_W, 8, `err_count` width.

Ports:
- clk  in  1  system clock; single clock domain.
- rstn  in  1  reset, synchronous, active-low.
- ts_data  in  8  TS byte.
- ts_valid  in  1  byte strobe; `ts_data` is sampled only when high; gaps are allowed.
- clr_count  in  1  clears `err_count` (driven by the controller's reset-counter strobe).
- valid  out  1  high while in LOCKED.
- sync  out  1  one-cycle pulse per accepted packet sync byte.
- err_count  out  CNT_W  saturating error count.

Behaviour:
- Reset (rstn=0 at a clk edge):
  - state=HUNT; valid=0, sync=0, err_count=0.
  - pos=0, hits=0, miss=0.
  - All table entries invalid.
  - Reset mid-packet discards everything.
- pos (0..PKT_LEN-1) advances only on a ts_valid beat; it wraps from PKT_LEN-1 to 0. In HUNT pos is not used.
- HUNT:
  - A beat with ts_data=0x47 moves to VERIFY with pos=1, hits=1.
  - Any other byte stays in HUNT.
- VERIFY, beat at pos=0:
  - ts_data=0x47: hits+1. When hits+1=LOCK_N, go to LOCKED with miss=0, and parse this packet.
  - Otherwise: go to HUNT with hits=0.
- LOCKED, beat at pos=0:
  - ts_data=0x47: miss=0 and parse the packet.
  - Otherwise: miss+1 and do not parse the packet; pos keeps flywheeling.
  - When miss reaches LOSS_N: go to HUNT, invalidate all table entries, and increment err_count by 1.
- Output timing:
  - valid = registered (state==LOCKED); it changes the cycle after the deciding beat.
  - sync pulses high for exactly one cycle, the cycle after every 0x47 accepted at pos=0 in LOCKED, including the locking beat.
- Header parse (parsed packets only):
  - pos1: TEI = ts_data[7], PID[12:8] = ts_data[4:0].
  - pos2: PID[7:0].
  - pos3: AFC = ts_data[5:4], CC = ts_data[3:0]. The check is evaluated on the pos3 beat.
- Check rules:
  - TEI=1 counts as an error; no CC check and no table update for that packet.
  - PID=0x1FFF (null packet) is ignored.
  - Table hit: expected = last+1 mod 16 if AFC is 01 or 11 (payload present); expected = last if AFC is 00 or 10. A mismatch counts as an error. last <= CC in either case.
  - Table miss with a free entry: allocate the lowest free index, store PID and CC; no error.
  - Table miss with the table full: the packet is untracked; no error.
- err_count:
  - Saturates at 2^CNT_W-1.
  - Registered; updates the cycle after the pos3 beat (or after the lock-loss beat).
  - At most one increment per cycle.
  - clr_count=1: err_count <= 1 if an increment event occurs in that cycle, else 0. clr_count has no effect on state, the table or valid.
- Byte-level events are all qualified by ts_valid. With ts_valid=0, only clr_count acts, and sync returns to 0.

Test Plan:
1. Reset sequence: assert rstn=0 for 2 cycles while ts_valid toggles random bytes -> valid=0, sync=0, err_count=0 throughout reset.
2. Clean lock: three 188-byte packets, PID 0x100, AFC=01, CC 0,1,2 -> valid=1 and sync=1 the cycle after the third 0x47; 4th and 5th packets (CC 3,4) give sync pulses; err_count stays 0.
3. CC errors:
   - PID 0x100 CC jumps 4->7 (AFC=01) -> err_count=1 one cycle after the pos3 beat.
   - Next packet has AFC=10 with CC=7 -> no change.
   - Next packet has AFC=01 with CC=7 -> err_count=2.
   - A TEI=1 packet -> err_count=3.
4. Table limits: PIDs 0x10, 0x11, 0x12, 0x13 and a fifth PID 0x14, each with arbitrary CC jumps after the first packet -> only the first four produce errors; a 0x1FFF packet with random CC produces none.
5. Lock loss and clear:
   - Corrupt sync bytes on 3 consecutive packets while locked -> valid=0 the cycle after the third miss, err_count+1, and the table is empty (next PID 0x100 packet with any CC gives no error after relock).
   - clr_count coincident with an increment event -> err_count=1.
6. Saturation: force more than 255 CC errors -> err_count holds at 255; clr_count=1 with no event -> 0.
